// File: rtl/seq_pkg.sv
// Shared types and encodings for the lab CPU instruction sequencer.
package seq_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_IF, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
        S_ALU, S_COMP, S_WR_REG, S_ADDR_A, S_ADDR_C, S_LD_ADDR, S_MEM_RD,
        S_STR_B, S_STR_C, S_MEM_WR, S_HALT, S_FAULT
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] NSEL_RD = 3'b100;
    localparam logic [2:0] NSEL_RM = 3'b010;
    localparam logic [2:0] NSEL_RN = 3'b001;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    // States that hold a memory command until mem_ready.
    function automatic logic is_wait(input state_t s);
        return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Counts consecutive stalled cycles in a memory-wait state and flags expiry.
module mem_timeout #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Every wait state is entered from a non-wait state or on a ready cycle,
    // so clearing outside stalls also clears on entry.
    always_comb begin
        cnt_d = '0;
        if (wait_i && !ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = wait_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: drives memory-side and datapath controls.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic [1:0] mem_cmd,
    output logic       addr_sel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_ir,
    output logic       load_addr,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       asel,
    output logic       bsel,
    output logic       halted,
    output logic       fault,
    output logic [4:0] dbg_state
);

    // Memory handshake: mem_cmd is held steady for as long as the FSM sits in
    // IF/MEM_RD/MEM_WR; the access completes on the cycle mem_ready is high.
    state_t state_q, state_d;
    logic   expired;

    mem_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .wait_i    (is_wait(state_q)),
        .ready_i   (mem_ready),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_cmd   = MEM_NONE;
        addr_sel  = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        nsel      = 3'b000;
        vsel      = VSEL_C;
        asel      = 1'b0;
        bsel      = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_RESET: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_IF;
            end
            S_IF: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = mem_ready;
                if (expired)        state_d = S_FAULT;
                else if (mem_ready) state_d = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OPC_MOV && op == OP_MOV_IMM)
                    state_d = S_WR_IMM;
                else if ((opcode == OPC_MOV && op == OP_MOV_REG) || opcode == OPC_ALU)
                    state_d = S_GET_A;
                else if ((opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM)
                    state_d = S_ADDR_A;
                else if (opcode == OPC_HALT)
                    state_d = S_HALT;
                else
                    state_d = S_IF;
            end
            S_WR_IMM: begin
                nsel    = NSEL_RN;
                vsel    = VSEL_IMM;
                write   = 1'b1;
                state_d = S_IF;
            end
            S_GET_A: begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                nsel    = NSEL_RM;
                loadb   = 1'b1;
                state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_COMP : S_ALU;
            end
            S_ALU: begin
                // MOV reg and MVN pass only the (shifted) B operand through.
                loadc   = 1'b1;
                asel    = (opcode == OPC_MOV) || (opcode == OPC_ALU && op == OP_MVN);
                state_d = S_WR_REG;
            end
            S_COMP: begin
                loads   = 1'b1;
                state_d = S_IF;
            end
            S_WR_REG: begin
                nsel    = NSEL_RD;
                vsel    = VSEL_C;
                write   = 1'b1;
                state_d = S_IF;
            end
            S_ADDR_A: begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = S_ADDR_C;
            end
            S_ADDR_C: begin
                bsel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr = 1'b1;
                state_d   = (opcode == OPC_LDR) ? S_MEM_RD : S_STR_B;
            end
            S_MEM_RD: begin
                mem_cmd = MEM_READ;
                if (mem_ready) begin
                    nsel    = NSEL_RD;
                    vsel    = VSEL_MDATA;
                    write   = 1'b1;
                    state_d = S_IF;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_STR_B: begin
                nsel    = NSEL_RD;
                loadb   = 1'b1;
                state_d = S_STR_C;
            end
            S_STR_C: begin
                asel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd = MEM_WRITE;
                if (mem_ready)    state_d = S_IF;
                else if (expired) state_d = S_FAULT;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_RESET;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: walks each instruction class cycle by cycle.
module tb_instruction_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       mem_ready = 1'b0;
  logic [1:0] mem_cmd;
  logic       addr_sel, load_pc, reset_pc, load_ir, load_addr;
  logic       loada, loadb, loadc, loads, write;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       asel, bsel, halted, fault;
  logic [4:0] dbg_state;
  logic [20:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  // enables: {addr_sel, load_pc, reset_pc, load_ir, load_addr, loada, loadb, loadc, loads, write}
  localparam logic [9:0] E_NONE  = 10'b0000000000;
  localparam logic [9:0] E_RST   = 10'b0110000000;
  localparam logic [9:0] E_IFR   = 10'b1001000000;
  localparam logic [9:0] E_IF    = 10'b1000000000;
  localparam logic [9:0] E_UPD   = 10'b0100000000;
  localparam logic [9:0] E_LADDR = 10'b0000100000;
  localparam logic [9:0] E_LA    = 10'b0000010000;
  localparam logic [9:0] E_LB    = 10'b0000001000;
  localparam logic [9:0] E_LC    = 10'b0000000100;
  localparam logic [9:0] E_LS    = 10'b0000000010;
  localparam logic [9:0] E_WR    = 10'b0000000001;
  // flags: {asel, bsel, halted, fault}
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_ASEL  = 4'b1000;
  localparam logic [3:0] F_BSEL  = 4'b0100;
  localparam logic [3:0] F_HALT  = 4'b0010;
  localparam logic [3:0] F_FAULT = 4'b0001;

  always #5 clk = ~clk;

  instruction_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .mem_cmd(mem_cmd), .addr_sel(addr_sel), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_ir(load_ir), .load_addr(load_addr), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .nsel(nsel), .vsel(vsel),
    .asel(asel), .bsel(bsel), .halted(halted), .fault(fault), .dbg_state(dbg_state)
  );

  assign ctl = {mem_cmd, addr_sel, load_pc, reset_pc, load_ir, load_addr, loada, loadb,
                loadc, loads, write, nsel, vsel, asel, bsel, halted, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_now(input string tag, input state_t s, input logic [1:0] cmd,
                            input logic [9:0] en, input logic [2:0] ns,
                            input logic [1:0] vs, input logic [3:0] fl);
    logic [20:0] exp_ctl;
    exp_ctl = {cmd, en, ns, vs, fl};
    check({tag, ".state"}, 32'(dbg_state), 32'(s));
    check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
  endtask

  // Called just after a rising edge: drive mem_ready, check mid-cycle, advance one clock.
  task automatic cyc(input string tag, input logic r, input state_t s, input logic [1:0] cmd,
                     input logic [9:0] en, input logic [2:0] ns, input logic [1:0] vs,
                     input logic [3:0] fl);
    mem_ready = r;
    @(negedge clk);
    expect_now(tag, s, cmd, en, ns, vs, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    expect_now({tag, ".assert"}, S_RESET, MEM_NONE, E_RST, 3'b000, 2'b00, F_NONE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc({tag, ".release"}, 1'b0, S_RESET, MEM_NONE, E_RST, 3'b000, 2'b00, F_NONE);
  endtask

  // IF (ready at once), UPD_PC, DECODE; the bench plays the IR once it is loaded.
  task automatic fetch(input string tag, input logic [2:0] opc, input logic [1:0] o);
    cyc({tag, ".if"}, 1'b1, S_IF, MEM_READ, E_IFR, 3'b000, 2'b00, F_NONE);
    opcode = opc;
    op = o;
    cyc({tag, ".upd"}, 1'b0, S_UPD_PC, MEM_NONE, E_UPD, 3'b000, 2'b00, F_NONE);
    cyc({tag, ".dec"}, 1'b0, S_DECODE, MEM_NONE, E_NONE, 3'b000, 2'b00, F_NONE);
  endtask

  initial begin
    #2;
    do_reset("rst0");

    fetch("mov_imm", 3'b110, 2'b10);
    cyc("mov_imm.wr", 1'b0, S_WR_IMM, MEM_NONE, E_WR, 3'b001, 2'b10, F_NONE);

    fetch("add", 3'b101, 2'b00);
    cyc("add.ga", 1'b0, S_GET_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("add.gb", 1'b0, S_GET_B, MEM_NONE, E_LB, 3'b010, 2'b00, F_NONE);
    cyc("add.alu", 1'b0, S_ALU, MEM_NONE, E_LC, 3'b000, 2'b00, F_NONE);
    cyc("add.wr", 1'b0, S_WR_REG, MEM_NONE, E_WR, 3'b100, 2'b00, F_NONE);

    fetch("ldr", 3'b011, 2'b00);
    cyc("ldr.aa", 1'b0, S_ADDR_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("ldr.ac", 1'b0, S_ADDR_C, MEM_NONE, E_LC, 3'b000, 2'b00, F_BSEL);
    cyc("ldr.la", 1'b0, S_LD_ADDR, MEM_NONE, E_LADDR, 3'b000, 2'b00, F_NONE);
    for (int i = 0; i < 3; i++)
      cyc("ldr.wait", 1'b0, S_MEM_RD, MEM_READ, E_NONE, 3'b000, 2'b00, F_NONE);
    cyc("ldr.done", 1'b1, S_MEM_RD, MEM_READ, E_WR, 3'b100, 2'b11, F_NONE);

    fetch("str", 3'b100, 2'b00);
    cyc("str.aa", 1'b0, S_ADDR_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("str.ac", 1'b0, S_ADDR_C, MEM_NONE, E_LC, 3'b000, 2'b00, F_BSEL);
    cyc("str.la", 1'b0, S_LD_ADDR, MEM_NONE, E_LADDR, 3'b000, 2'b00, F_NONE);
    cyc("str.b", 1'b0, S_STR_B, MEM_NONE, E_LB, 3'b100, 2'b00, F_NONE);
    cyc("str.c", 1'b0, S_STR_C, MEM_NONE, E_LC, 3'b000, 2'b00, F_ASEL);
    for (int i = 0; i < 2; i++)
      cyc("str.wait", 1'b0, S_MEM_WR, MEM_WRITE, E_NONE, 3'b000, 2'b00, F_NONE);
    cyc("str.done", 1'b1, S_MEM_WR, MEM_WRITE, E_NONE, 3'b000, 2'b00, F_NONE);

    fetch("cmp", 3'b101, 2'b01);
    cyc("cmp.ga", 1'b0, S_GET_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("cmp.gb", 1'b0, S_GET_B, MEM_NONE, E_LB, 3'b010, 2'b00, F_NONE);
    cyc("cmp.s", 1'b0, S_COMP, MEM_NONE, E_LS, 3'b000, 2'b00, F_NONE);

    fetch("mvn", 3'b101, 2'b11);
    cyc("mvn.ga", 1'b0, S_GET_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("mvn.gb", 1'b0, S_GET_B, MEM_NONE, E_LB, 3'b010, 2'b00, F_NONE);
    cyc("mvn.alu", 1'b0, S_ALU, MEM_NONE, E_LC, 3'b000, 2'b00, F_ASEL);
    cyc("mvn.wr", 1'b0, S_WR_REG, MEM_NONE, E_WR, 3'b100, 2'b00, F_NONE);

    fetch("mov_reg", 3'b110, 2'b00);
    cyc("mov_reg.ga", 1'b0, S_GET_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("mov_reg.gb", 1'b0, S_GET_B, MEM_NONE, E_LB, 3'b010, 2'b00, F_NONE);
    cyc("mov_reg.alu", 1'b0, S_ALU, MEM_NONE, E_LC, 3'b000, 2'b00, F_ASEL);
    cyc("mov_reg.wr", 1'b0, S_WR_REG, MEM_NONE, E_WR, 3'b100, 2'b00, F_NONE);

    // LDR with a nonzero op field is illegal and falls back to fetch.
    fetch("illegal", 3'b011, 2'b01);

    // Ready on the last allowed stall cycle still completes the fetch.
    for (int i = 0; i < 15; i++)
      cyc("edge.stall", 1'b0, S_IF, MEM_READ, E_IF, 3'b000, 2'b00, F_NONE);
    cyc("edge.ready", 1'b1, S_IF, MEM_READ, E_IFR, 3'b000, 2'b00, F_NONE);
    opcode = 3'b000;
    op = 2'b00;
    cyc("edge.upd", 1'b0, S_UPD_PC, MEM_NONE, E_UPD, 3'b000, 2'b00, F_NONE);
    cyc("edge.dec", 1'b0, S_DECODE, MEM_NONE, E_NONE, 3'b000, 2'b00, F_NONE);

    // Sixteen stalled fetch cycles, then FAULT latches regardless of mem_ready.
    for (int i = 0; i < 16; i++)
      cyc("to.stall", 1'b0, S_IF, MEM_READ, E_IF, 3'b000, 2'b00, F_NONE);
    cyc("to.fault0", 1'b1, S_FAULT, MEM_NONE, E_NONE, 3'b000, 2'b00, F_FAULT);
    cyc("to.fault1", 1'b0, S_FAULT, MEM_NONE, E_NONE, 3'b000, 2'b00, F_FAULT);
    cyc("to.fault2", 1'b1, S_FAULT, MEM_NONE, E_NONE, 3'b000, 2'b00, F_FAULT);

    do_reset("rst1");
    fetch("halt", 3'b111, 2'b00);
    for (int i = 0; i < 3; i++)
      cyc("halt.hold", 1'(i % 2), S_HALT, MEM_NONE, E_NONE, 3'b000, 2'b00, F_HALT);

    // Reset asserted mid-write drops the memory command at once.
    do_reset("rst2");
    fetch("str2", 3'b100, 2'b00);
    cyc("str2.aa", 1'b0, S_ADDR_A, MEM_NONE, E_LA, 3'b001, 2'b00, F_NONE);
    cyc("str2.ac", 1'b0, S_ADDR_C, MEM_NONE, E_LC, 3'b000, 2'b00, F_BSEL);
    cyc("str2.la", 1'b0, S_LD_ADDR, MEM_NONE, E_LADDR, 3'b000, 2'b00, F_NONE);
    cyc("str2.b", 1'b0, S_STR_B, MEM_NONE, E_LB, 3'b100, 2'b00, F_NONE);
    cyc("str2.c", 1'b0, S_STR_C, MEM_NONE, E_LC, 3'b000, 2'b00, F_ASEL);
    mem_ready = 1'b0;
    #1;
    expect_now("abort.pre", S_MEM_WR, MEM_WRITE, E_NONE, 3'b000, 2'b00, F_NONE);
    rst = 1'b0;
    #1;
    expect_now("abort.now", S_RESET, MEM_NONE, E_RST, 3'b000, 2'b00, F_NONE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("abort.rel", 1'b0, S_RESET, MEM_NONE, E_RST, 3'b000, 2'b00, F_NONE);
    cyc("abort.if", 1'b1, S_IF, MEM_READ, E_IFR, 3'b000, 2'b00, F_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
